// File: rtl/sd_image_loader_if.sv
// SD file-reader stream and framebuffer write bus.
// The loader is the master; the reader/framebuffer side is the slave.
interface sd_image_loader_if #(
  parameter int ADDR_W = 19
);
  logic              file_found;
  logic [2:0]        fatstate;
  logic              outreq;
  logic [7:0]        outbyte;
  logic              sd_rst_n;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_wdata;

  modport master (
    input  file_found,
    input  fatstate,
    input  outreq,
    input  outbyte,
    output sd_rst_n,
    output fb_we,
    output fb_addr,
    output fb_wdata
  );

  modport slave (
    output file_found,
    output fatstate,
    output outreq,
    output outbyte,
    input  sd_rst_n,
    input  fb_we,
    input  fb_addr,
    input  fb_wdata
  );
endinterface

// File: rtl/sd_image_loader.sv
// Resets the SD file reader, skips the file header and packs
// the byte stream into 24-bit pixels written to the framebuffer.
module sd_image_loader #(
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int HDR_BYTES      = 54,
  parameter int ADDR_W         = 19,
  parameter int SD_RST_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  sd_image_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int RW   = $clog2(SD_RST_CYCLES + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW   = $clog2(HDR_BYTES + 2);

  localparam logic [RW-1:0] RST_LAST =
    RW'(SD_RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HDR_LAST =
    HW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
  localparam logic [ADDR_W-1:0] PIX_LAST =
    ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SD_RST,
    S_WAIT,
    S_SKIP,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [RW-1:0]     rst_cnt;
  logic [TW-1:0]     tmo;
  logic [HW-1:0]     hdr_cnt;
  logic [1:0]        phase;
  logic [7:0]        r_byte;
  logic [7:0]        g_byte;
  logic [ADDR_W-1:0] pix;

  logic go;
  logic last_pix;
  logic tmo_hit;
  logic fat_end;
  logic fail;

  always_comb begin
    go       = 1'b0;
    last_pix = 1'b0;
    tmo_hit  = 1'b0;
    fat_end  = 1'b0;
    fail     = 1'b0;
    go = start && !busy &&
         (state inside {S_IDLE, S_DONE, S_ERROR});
    last_pix = bus.outreq && (phase == 2'd2) &&
               (pix == PIX_LAST);
    tmo_hit = !bus.outreq && (tmo == TMO_LAST);
    fat_end = (bus.fatstate == 3'd6);
    // Completing the last pixel beats any same-cycle failure.
    unique case (state)
      S_WAIT: fail = !bus.file_found && tmo_hit;
      S_SKIP: fail = fat_end || tmo_hit;
      S_LOAD: fail = !last_pix && (fat_end || tmo_hit);
      default: fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      tmo          <= '0;
      hdr_cnt      <= '0;
      phase        <= '0;
      r_byte       <= '0;
      g_byte       <= '0;
      pix          <= '0;
      bus.sd_rst_n <= 1'b0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_wdata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.fb_we <= 1'b0;
      if (go) begin
        state        <= S_SD_RST;
        rst_cnt      <= '0;
        pix          <= '0;
        bus.fb_addr  <= '0;
        bus.sd_rst_n <= 1'b0;
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
      end else if (fail) begin
        state        <= S_ERROR;
        bus.sd_rst_n <= 1'b0;
        busy         <= 1'b0;
        error        <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: bus.sd_rst_n <= 1'b0;
          S_SD_RST: begin
            if (rst_cnt == RST_LAST) begin
              state        <= S_WAIT;
              tmo          <= '0;
              bus.sd_rst_n <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.file_found) begin
              state   <= (HDR_BYTES == 0) ? S_LOAD : S_SKIP;
              tmo     <= '0;
              hdr_cnt <= '0;
              phase   <= '0;
            end else if (bus.outreq) begin
              tmo <= '0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_SKIP: begin
            if (bus.outreq) begin
              tmo <= '0;
              if (hdr_cnt == HDR_LAST) begin
                state <= S_LOAD;
                phase <= '0;
              end else begin
                hdr_cnt <= hdr_cnt + 1'b1;
              end
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_LOAD: begin
            if (bus.outreq) begin
              tmo <= '0;
              unique case (phase)
                2'd0: begin
                  r_byte <= bus.outbyte;
                  phase  <= 2'd1;
                end
                2'd1: begin
                  g_byte <= bus.outbyte;
                  phase  <= 2'd2;
                end
                default: begin
                  bus.fb_we    <= 1'b1;
                  bus.fb_addr  <= pix;
                  bus.fb_wdata <= {r_byte, g_byte, bus.outbyte};
                  pix          <= pix + 1'b1;
                  phase        <= 2'd0;
                  if (last_pix) state <= S_DONE;
                end
              endcase
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_DONE: begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          S_ERROR: bus.sd_rst_n <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_image_loader.sv
// Directed bench for sd_image_loader on a 4x2 image
// with a 2-byte header and short reset/timeout windows.
module tb_sd_image_loader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int AW = 3;
  localparam int RC = 16;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;

  sd_image_loader_if #(.ADDR_W(AW)) bus ();

  sd_image_loader #(
    .IMG_W(W), .IMG_H(H), .HDR_BYTES(HB), .ADDR_W(AW),
    .SD_RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        req;
    logic [7:0]  b;
    logic [2:0]  fat;
    logic        we;
    logic [2:0]  addr;
    logic [23:0] data;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;

  always @(negedge clk) if (bus.fb_we) we_cnt++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void push(
    input logic st, input logic req, input logic [7:0] b,
    input logic [2:0] fat, input logic we,
    input logic [2:0] addr, input logic [23:0] data,
    input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.req = req; v.b = b; v.fat = fat;
    v.we = we; v.addr = addr; v.data = data;
    v.bsy = bsy; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rst();
    repeat (RC - 1) @(negedge clk);
    chk("sd_rst_n_held", 32'(bus.sd_rst_n), 32'd0);
    @(negedge clk);
    chk("sd_rst_n_release", 32'(bus.sd_rst_n), 32'd1);
  endtask

  task automatic stream(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.outreq  = 1'b1;
      bus.outbyte = base + 8'(i);
      @(negedge clk);
    end
    bus.outreq = 1'b0;
  endtask

  initial begin
    bus.file_found = 1'b0;
    bus.fatstate   = 3'd0;
    bus.outreq     = 1'b0;
    bus.outbyte    = 8'd0;

    // header records, then 24 pixel bytes 0x01..0x18
    push(0, 1, 8'hAA, 0, 0, 0, 0, 1, 0);
    push(0, 1, 8'hBB, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 24; k++) begin
      logic [23:0] d;
      d = {8'(k - 1), 8'(k), 8'(k + 1)};
      push((k == 10), 1, 8'(k + 1),
           (k == 23) ? 3'd6 : 3'd0,
           (k % 3 == 2), 3'(k / 3), d, 1, 0);
      if (k == 5 || k == 13)
        push(0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    end
    for (int k = 0; k < 3; k++)
      push(0, 1, 8'hE0 + 8'(k), 0, 0, 0, 0, 0, 1);

    #2;
    chk("rst_sd_rst_n", 32'(bus.sd_rst_n), 32'd0);
    chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_wdata", 32'(bus.fb_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // full load with gaps, ignored mid-load start,
    // and fatstate=6 coincident with the last pixel
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_sd_rst_n", 32'(bus.sd_rst_n), 32'd0);
    wait_rst();
    bus.file_found = 1'b1;
    @(negedge clk);
    we_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      start        = vecs[i].st;
      bus.outreq   = vecs[i].req;
      bus.outbyte  = vecs[i].b;
      bus.fatstate = vecs[i].fat;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i),
          32'(bus.fb_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i),
            32'(bus.fb_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i),
            32'(bus.fb_wdata), 32'(vecs[i].data));
      end
      chk($sformatf("vec%0d_busy", i),
          32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("vec%0d_done", i),
          32'(done), 32'(vecs[i].dn));
    end
    start = 1'b0;
    bus.outreq = 1'b0;
    bus.fatstate = 3'd0;
    chk("load_we_count", 32'(we_cnt), 32'd8);
    chk("load_error", 32'(error), 32'd0);
    chk("load_sd_rst_n", 32'(bus.sd_rst_n), 32'd1);

    // reload from DONE, file never found -> timeout
    bus.file_found = 1'b0;
    do_start();
    chk("reload_addr", 32'(bus.fb_addr), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    wait_rst();
    repeat (TO - 1) @(negedge clk);
    chk("tmo_early", 32'(error), 32'd0);
    @(negedge clk);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_sd_rst_n", 32'(bus.sd_rst_n), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_done", 32'(done), 32'd0);

    // short file: 2 pixels + 2 bytes, then fatstate=6
    do_start();
    chk("short_clr_error", 32'(error), 32'd0);
    wait_rst();
    bus.file_found = 1'b1;
    @(negedge clk);
    we_cnt = 0;
    stream(HB + 8, 8'h30);
    bus.fatstate = 3'd6;
    @(negedge clk);
    bus.fatstate = 3'd0;
    chk("short_error", 32'(error), 32'd1);
    chk("short_done", 32'(done), 32'd0);
    chk("short_busy", 32'(busy), 32'd0);
    chk("short_we_count", 32'(we_cnt), 32'd2);
    chk("short_addr", 32'(bus.fb_addr), 32'd1);
    chk("short_data", 32'(bus.fb_wdata), 32'h353637);

    // asynchronous reset mid-load
    do_start();
    wait_rst();
    @(negedge clk);
    stream(HB + 6, 8'h40);
    chk("pre_rst_we", 32'(bus.fb_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sd_rst_n", 32'(bus.sd_rst_n), 32'd0);
    chk("arst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("arst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("arst_fb_wdata", 32'(bus.fb_wdata), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
